channel_scheduler: RTL and testbench
====================================

Name: channel_scheduler

Overview:
- Sequencer for the 2-way stream demux (channel select + per-channel valid/ready gating) in the RX sample path.
- Drives the demux `channel` select so a shared upstream sample stream alternates between consumer 1 and consumer 2 in bursts of programmable length.
- Skips disabled channels and breaks persistent stalls by dropping samples.
- Exports strobes and counters for the host status registers.

Parameters:
- CNT_W, 8: width of the burst length and burst counter.
- STALL_MAX, 64: consecutive stalled cycles on the selected channel before one sample is dropped (must be ≥1).
- DROP_W, 16: width of the saturating drop counter.

Ports:
- clk_in  input  1  system clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  scheduler run enable.
- ch_en  input  2  per-channel enable; bit0 = channel 0, bit1 = channel 1.
- burst_len  input  CNT_W  beats per burst; 0 is treated as 1.
- in_valid  input  1  upstream sample valid (same signal fed to the demux).
- in_ready_1  input  1  consumer 1 ready.
- in_ready_2  input  1  consumer 2 ready.
- channel  output  1  registered select to the demux; 0 = consumer 1, 1 = consumer 2.
- sel_valid  output  1  registered; high when `channel` is valid (state ACTIVE). Upstream must not present data while low.
- xfer  output  1  combinational; accepted beat = sel_valid & in_valid & ready_sel.
- drop  output  1  registered 1-cycle pulse; a stalled sample was discarded.
- frame_start  output  1  registered 1-cycle pulse, asserted the cycle after the first beat of a channel-0 burst.
- drop_count  output  DROP_W  saturating count of drops; cleared only by reset.

Behaviour:
- Reset values: channel=0, sel_valid=0, drop=0, frame_start=0, drop_count=0.
- Internal reset values: state=IDLE, beat_cnt=0, stall_cnt=0, len_q=1.
- ready_sel = channel ? in_ready_2 : in_ready_1.
- States: IDLE, ACTIVE.
- IDLE -> ACTIVE: when enable=1 and ch_en≠0.
  - channel is set to the lowest enabled channel.
  - len_q ← max(burst_len,1); counters cleared.
  - sel_valid rises in the same edge, so the first xfer is possible one cycle after the enable condition is seen.
- ACTIVE -> IDLE: next edge after enable=0 or ch_en=0, regardless of burst position. Counters clear, sel_valid=0, channel holds its last value.
- Beat accounting in ACTIVE: a beat is an xfer or a drop.
  - Each beat increments beat_cnt.
  - On the beat where beat_cnt==len_q-1, end the burst:
    - beat_cnt←0.
    - len_q←max(burst_len,1); burst_len is sampled only at burst boundaries.
    - channel←other channel if that channel is enabled, otherwise the channel is unchanged.
- Mid-burst disable: if ch_en[channel] drops while ACTIVE and the other channel is enabled, switch on the next edge. beat_cnt←0, stall_cnt←0, len_q reloaded; the partial burst is abandoned.
- Stall rule:
  - stall_cnt increments each cycle with sel_valid & in_valid & !ready_sel.
  - stall_cnt clears on any xfer, on in_valid=0, and on any channel change.
  - When stall_cnt reaches STALL_MAX-1 while still stalled:
    - drop pulses next cycle; the beat counts toward the burst.
    - drop_count increments, saturating at all-ones.
    - stall_cnt←0.
  - An upstream that must discard on drop does so in the cycle drop is high.
- frame_start is set the cycle after an xfer with channel=0 and beat_cnt=0. A drop at beat 0 does not assert it.
- Simultaneous events:
  - Burst end and disable of the other channel in the same cycle: stay on the current channel.
  - enable=0 in the same cycle as an xfer: the xfer is still counted as accepted, but ACTIVE exits on that edge.
- Single enabled channel: bursts repeat on that channel, and frame_start behaves normally only if it is channel 0.
- Reset asserted mid-burst: all state returns to reset values immediately (asynchronous); no partial-beat bookkeeping survives.

Decomposition:
- Shared package holds:
  - state encoding localparams: ST_IDLE, ST_ACTIVE.
  - channel constants: CH_1=0, CH_2=1.
  - default CNT_W and DROP_W.
- One natural sub-module: sat_counter (parameterized width, increment + clear, saturating), used for drop_count.
- Burst and stall counters stay inline.

Test Plan:
- Basic alternation: burst_len=3, ch_en=2'b11, in_valid=1, both ready=1 -> xfer every cycle; channel pattern 0,0,0,1,1,1,0…; frame_start pulses once per 6 beats.
- burst_len=0, ch_en=2'b11 -> channel toggles every beat (treated as 1).
- One channel enabled: ch_en=2'b10 at start -> channel=1 for all beats; frame_start never asserts.
- Stall drop: STALL_MAX=4, selected consumer ready=0 and in_valid held for 10 cycles -> drop pulses at cycles 4 and 8 after the stall begins; drop_count=2; the burst position advances by 2.
- Mid-burst disable: burst_len=8, clear ch_en[0] after 3 beats on channel 0 -> channel=1 next cycle; beat_cnt restarts at 0.
- Async reset mid-burst: reset_n low between clock edges during ACTIVE -> sel_valid=0, channel=0, drop_count=0 immediately. Before reapplying enable, restore ch_en=2'b11 so the restart condition is deterministic. After reset_n and enable are reapplied, the first burst starts on channel 0 with full length.

Source files
------------

// File: rtl/channel_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// channel_scheduler_pkg : shared types and constants for the RX channel scheduler
// Revision: 1.0
// ============================================================================
package channel_scheduler_pkg;

   localparam int DEF_CNT_W  = 8;
   localparam int DEF_DROP_W = 16;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   localparam logic CH_1 = 1'b0;
   localparam logic CH_2 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/channel_scheduler_sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter : up-counter with synchronous clear that sticks at all-ones
// Revision: 1.0
// ============================================================================
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + ONE;
      end
   end

endmodule
`default_nettype wire

// File: rtl/channel_scheduler.sv
`default_nettype none
// ============================================================================
// channel_scheduler : burst sequencer driving the 2-way RX stream demux select,
//                     with disabled-channel skipping and stall-break dropping
// Revision: 1.0
// ============================================================================
module channel_scheduler
   import channel_scheduler_pkg::*;
#(
   parameter int CNT_W     = DEF_CNT_W,
   parameter int STALL_MAX = 64,
   parameter int DROP_W    = DEF_DROP_W
) (
   input  logic              clk_in,
   input  logic              reset_n,
   input  logic              enable,
   input  logic [1:0]        ch_en,
   input  logic [CNT_W-1:0]  burst_len,
   input  logic              in_valid,
   input  logic              in_ready_1,
   input  logic              in_ready_2,
   output logic              channel,
   output logic              sel_valid,
   output logic              xfer,
   output logic              drop,
   output logic              frame_start,
   output logic [DROP_W-1:0] drop_count
);

   localparam int                 STALL_W    = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_MAX - 1);
   localparam logic [STALL_W-1:0] STALL_ONE  = STALL_W'(1);
   localparam logic [CNT_W-1:0]   ONE        = CNT_W'(1);

   state_t             state;
   logic [CNT_W-1:0]   beat_cnt;
   logic [CNT_W-1:0]   len_q;
   logic [STALL_W-1:0] stall_cnt;

   logic               ready_sel;
   logic               stalled;
   logic               drop_evt;
   logic               beat;
   logic               burst_end;
   logic               cur_en;
   logic               other_en;
   logic [CNT_W-1:0]   len_load;

   assign ready_sel = channel ? in_ready_2 : in_ready_1;
   assign xfer      = sel_valid & in_valid & ready_sel;
   assign stalled   = sel_valid & in_valid & ~ready_sel;
   assign drop_evt  = stalled & (stall_cnt == STALL_LAST);
   // A discarded sample still occupies a slot in the burst.
   assign beat      = xfer | drop_evt;
   assign burst_end = beat & (beat_cnt == (len_q - ONE));
   assign cur_en    = ch_en[channel];
   assign other_en  = ch_en[~channel];
   assign len_load  = (burst_len == '0) ? ONE : burst_len;

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         channel     <= CH_1;
         sel_valid   <= 1'b0;
         drop        <= 1'b0;
         frame_start <= 1'b0;
         beat_cnt    <= '0;
         stall_cnt   <= '0;
         len_q       <= ONE;
      end else begin
         drop        <= drop_evt;
         frame_start <= xfer & (channel == CH_1) & (beat_cnt == '0);
         case (state)
            ST_IDLE: begin
               if (enable && (ch_en != 2'b00)) begin
                  state     <= ST_ACTIVE;
                  sel_valid <= 1'b1;
                  channel   <= ch_en[0] ? CH_1 : CH_2;
                  len_q     <= len_load;
                  beat_cnt  <= '0;
                  stall_cnt <= '0;
               end
            end
            ST_ACTIVE: begin
               if (!enable || (ch_en == 2'b00)) begin
                  state     <= ST_IDLE;
                  sel_valid <= 1'b0;
                  beat_cnt  <= '0;
                  stall_cnt <= '0;
               end else if (!cur_en) begin
                  // Other channel must be enabled here; abandon the partial burst.
                  channel   <= ~channel;
                  beat_cnt  <= '0;
                  stall_cnt <= '0;
                  len_q     <= len_load;
               end else begin
                  if (burst_end) begin
                     beat_cnt <= '0;
                     len_q    <= len_load;
                  end else if (beat) begin
                     beat_cnt <= beat_cnt + ONE;
                  end

                  if (burst_end && other_en) begin
                     channel   <= ~channel;
                     stall_cnt <= '0;
                  end else if (stalled && !drop_evt) begin
                     stall_cnt <= stall_cnt + STALL_ONE;
                  end else begin
                     stall_cnt <= '0;
                  end
               end
            end
            default: begin
               state     <= ST_IDLE;
               sel_valid <= 1'b0;
            end
         endcase
      end
   end

   sat_counter #(
      .WIDTH (DROP_W)
   ) u_drop_cnt (
      .clk   (clk_in),
      .rst_n (reset_n),
      .clear (1'b0),
      .inc   (drop_evt),
      .count (drop_count)
   );

endmodule
`default_nettype wire

// File: tb/tb_channel_scheduler.sv
`default_nettype none
// ============================================================================
// tb_channel_scheduler : scenario tasks checked against a cycle reference model
// Revision: 1.0
// ============================================================================
module tb_channel_scheduler;

   localparam int CNT_W     = 8;
   localparam int STALL_MAX = 4;
   localparam int DROP_W    = 3;
   localparam int DC_MAX    = (1 << DROP_W) - 1;
   localparam int VW        = DROP_W + 4;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              enable;
   logic [1:0]        ch_en;
   logic [CNT_W-1:0]  burst_len;
   logic              in_valid;
   logic              in_ready_1;
   logic              in_ready_2;
   logic              channel;
   logic              sel_valid;
   logic              xfer;
   logic              drop;
   logic              frame_start;
   logic [DROP_W-1:0] drop_count;

   int pass_cnt = 0;
   int tot      = 0;

   // Reference model state, in specification terms
   int m_act, m_ch, m_pos, m_len, m_wait, m_drop, m_fs, m_dc;
   logic exp_xfer, obs_xfer;

   always #5 clk = ~clk;

   channel_scheduler #(
      .CNT_W     (CNT_W),
      .STALL_MAX (STALL_MAX),
      .DROP_W    (DROP_W)
   ) dut (
      .clk_in      (clk),
      .reset_n     (reset_n),
      .enable      (enable),
      .ch_en       (ch_en),
      .burst_len   (burst_len),
      .in_valid    (in_valid),
      .in_ready_1  (in_ready_1),
      .in_ready_2  (in_ready_2),
      .channel     (channel),
      .sel_valid   (sel_valid),
      .xfer        (xfer),
      .drop        (drop),
      .frame_start (frame_start),
      .drop_count  (drop_count)
   );

   function automatic int eff_len(int b);
      return (b == 0) ? 1 : b;
   endfunction

   function automatic void model_reset();
      m_act = 0; m_ch = 0; m_pos = 0; m_len = 1; m_wait = 0;
      m_drop = 0; m_fs = 0; m_dc = 0;
   endfunction

   function automatic void model_step();
      int  rdy, acc, stl, dr, nw, other;
      rdy   = (m_ch == 1) ? int'(in_ready_2) : int'(in_ready_1);
      acc   = (m_act == 1 && in_valid && rdy == 1) ? 1 : 0;
      stl   = (m_act == 1 && in_valid && rdy == 0) ? 1 : 0;
      dr    = (stl == 1 && m_wait == STALL_MAX - 1) ? 1 : 0;
      other = 1 - m_ch;
      m_fs   = (acc == 1 && m_ch == 0 && m_pos == 0) ? 1 : 0;
      m_drop = dr;
      if (dr == 1 && m_dc < DC_MAX) m_dc++;
      if (m_act == 0) begin
         if (enable && ch_en != 2'b00) begin
            m_act = 1; m_ch = ch_en[0] ? 0 : 1;
            m_len = eff_len(int'(burst_len)); m_pos = 0; m_wait = 0;
         end
      end else if (!enable || ch_en == 2'b00) begin
         m_act = 0; m_pos = 0; m_wait = 0;
      end else if (!ch_en[m_ch]) begin
         m_ch = other; m_pos = 0; m_wait = 0; m_len = eff_len(int'(burst_len));
      end else begin
         nw = (stl == 1 && dr == 0) ? m_wait + 1 : 0;
         if (acc == 1 || dr == 1) begin
            if (m_pos + 1 >= m_len) begin
               m_pos = 0; m_len = eff_len(int'(burst_len));
               if (ch_en[other]) begin m_ch = other; nw = 0; end
            end else begin
               m_pos++;
            end
         end
         m_wait = nw;
      end
   endfunction

   function automatic logic [VW-1:0] exp_vec();
      logic [31:0] dc;
      dc = m_dc;
      return {m_ch[0], m_act[0], m_drop[0], m_fs[0], dc[DROP_W-1:0]};
   endfunction

   function automatic logic [VW-1:0] obs_vec();
      return {channel, sel_valid, drop, frame_start, drop_count};
   endfunction

   task automatic tick();
      @(negedge clk);
      exp_xfer = (m_act == 1) && in_valid && ((m_ch == 1) ? in_ready_2 : in_ready_1);
      obs_xfer = xfer;
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle();
      enable = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset_n = 1'b0; enable = 1'b0; ch_en = 2'b11; burst_len = '0;
      in_valid = 1'b0; in_ready_1 = 1'b0; in_ready_2 = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      tot++;
      if (obs_vec() !== '0) $display("FAIL reset_state: got %b want %b", obs_vec(), {VW{1'b0}});
      else pass_cnt++;
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_alternation();
      int fs_seen = 0;
      go_idle();
      burst_len = 8'd3; ch_en = 2'b11; in_valid = 1'b1;
      in_ready_1 = 1'b1; in_ready_2 = 1'b1; enable = 1'b1;
      for (int i = 0; i < 13; i++) begin
         tick();
         if (frame_start) fs_seen++;
         tot++;
         if (obs_xfer !== exp_xfer) $display("FAIL alt_xfer i=%0d: got %b want %b", i, obs_xfer, exp_xfer);
         else pass_cnt++;
         tot++;
         if (obs_vec() !== exp_vec()) $display("FAIL alt_model i=%0d: got %b want %b", i, obs_vec(), exp_vec());
         else pass_cnt++;
         tot++;
         if (channel !== 1'((i / 3) % 2)) $display("FAIL alt_channel i=%0d: got %b want %0d", i, channel, (i / 3) % 2);
         else pass_cnt++;
      end
      tot++;
      if (fs_seen != 2) $display("FAIL alt_frame_count: got %0d want 2", fs_seen);
      else pass_cnt++;
   endtask

   task automatic test_len_zero();
      go_idle();
      burst_len = '0; ch_en = 2'b11; in_valid = 1'b1;
      in_ready_1 = 1'b1; in_ready_2 = 1'b1; enable = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         tot++;
         if (obs_vec() !== exp_vec()) $display("FAIL len0_model i=%0d: got %b want %b", i, obs_vec(), exp_vec());
         else pass_cnt++;
         tot++;
         if (channel !== 1'(i % 2)) $display("FAIL len0_channel i=%0d: got %b want %0d", i, channel, i % 2);
         else pass_cnt++;
      end
   endtask

   task automatic test_single_channel();
      go_idle();
      burst_len = 8'd2; ch_en = 2'b10; in_valid = 1'b1;
      in_ready_1 = 1'b1; in_ready_2 = 1'b1; enable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         tot++;
         if (obs_vec() !== exp_vec()) $display("FAIL single_model i=%0d: got %b want %b", i, obs_vec(), exp_vec());
         else pass_cnt++;
         tot++;
         if ({channel, frame_start} !== 2'b10) $display("FAIL single_ch_fs i=%0d: got %b want 10", i, {channel, frame_start});
         else pass_cnt++;
      end
   endtask

   task automatic test_stall_drop();
      go_idle();
      burst_len = 8'd8; ch_en = 2'b11; in_valid = 1'b0;
      in_ready_1 = 1'b0; in_ready_2 = 1'b1; enable = 1'b1;
      tick();
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         tot++;
         if (obs_vec() !== exp_vec()) $display("FAIL stall_model i=%0d: got %b want %b", i, obs_vec(), exp_vec());
         else pass_cnt++;
         tot++;
         if (drop !== (i == 3 || i == 7)) $display("FAIL stall_drop_pulse i=%0d: got %b want %b", i, drop, (i == 3 || i == 7));
         else pass_cnt++;
      end
      tot++;
      if (drop_count !== 3'd2) $display("FAIL stall_drop_count: got %0d want 2", drop_count);
      else pass_cnt++;
      // Two dropped beats already consumed, so six accepted beats finish the burst.
      in_ready_1 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         tot++;
         if (channel !== (i == 5)) $display("FAIL stall_burst_pos i=%0d: got %b want %b", i, channel, (i == 5));
         else pass_cnt++;
      end
   endtask

   task automatic test_mid_disable();
      go_idle();
      burst_len = 8'd8; ch_en = 2'b11; in_valid = 1'b1;
      in_ready_1 = 1'b1; in_ready_2 = 1'b1; enable = 1'b1;
      repeat (4) tick();
      ch_en = 2'b10;
      tick();
      tot++;
      if (obs_vec() !== exp_vec()) $display("FAIL middis_model: got %b want %b", obs_vec(), exp_vec());
      else pass_cnt++;
      tot++;
      if (channel !== 1'b1) $display("FAIL middis_switch: got %b want 1", channel);
      else pass_cnt++;
      ch_en = 2'b11;
      for (int k = 1; k <= 8; k++) begin
         tick();
         tot++;
         if (channel !== (k != 8)) $display("FAIL middis_restart k=%0d: got %b want %b", k, channel, (k != 8));
         else pass_cnt++;
      end
   endtask

   task automatic test_saturation();
      go_idle();
      burst_len = 8'd5; ch_en = 2'b01; in_valid = 1'b1;
      in_ready_1 = 1'b0; in_ready_2 = 1'b1; enable = 1'b1;
      for (int i = 0; i < 32; i++) begin
         tick();
         tot++;
         if (obs_vec() !== exp_vec()) $display("FAIL sat_model i=%0d: got %b want %b", i, obs_vec(), exp_vec());
         else pass_cnt++;
      end
      tot++;
      if (drop_count !== 3'b111) $display("FAIL sat_drop_count: got %0d want 7", drop_count);
      else pass_cnt++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         enable     = ($urandom_range(0, 19) != 0);
         if ($urandom_range(0, 9) == 0) ch_en = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) burst_len = CNT_W'($urandom_range(0, 4));
         in_valid   = ($urandom_range(0, 4) != 0);
         in_ready_1 = ($urandom_range(0, 2) != 0);
         in_ready_2 = ($urandom_range(0, 3) == 0);
         tick();
         tot++;
         if (obs_xfer !== exp_xfer) $display("FAIL rand_xfer i=%0d: got %b want %b", i, obs_xfer, exp_xfer);
         else pass_cnt++;
         tot++;
         if (obs_vec() !== exp_vec()) $display("FAIL rand_model i=%0d: got %b want %b", i, obs_vec(), exp_vec());
         else pass_cnt++;
      end
   endtask

   task automatic test_async_reset();
      go_idle();
      burst_len = 8'd3; ch_en = 2'b11; in_valid = 1'b1;
      in_ready_1 = 1'b1; in_ready_2 = 1'b1; enable = 1'b1;
      repeat (5) tick();
      #3;
      reset_n = 1'b0;
      #1;
      tot++;
      if (obs_vec() !== '0) $display("FAIL async_reset: got %b want %b", obs_vec(), {VW{1'b0}});
      else pass_cnt++;
      model_reset();
      ch_en = 2'b11; enable = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk);
      #1;
      enable = 1'b1; burst_len = 8'd3;
      for (int i = 0; i < 8; i++) begin
         tick();
         tot++;
         if (obs_vec() !== exp_vec()) $display("FAIL restart_model i=%0d: got %b want %b", i, obs_vec(), exp_vec());
         else pass_cnt++;
         tot++;
         if (channel !== 1'((i / 3) % 2)) $display("FAIL restart_channel i=%0d: got %b want %0d", i, channel, (i / 3) % 2);
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_alternation();
      test_len_zero();
      test_single_channel();
      test_stall_drop();
      test_mid_disable();
      test_saturation();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, tot);
      $finish;
   end

endmodule
`default_nettype wire
